// File: rtl/agc_pkg.sv
// rtl/agc_pkg.sv - shared state type, constants and helpers for the AGC gain loop
package agc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_TRACK  = 2'd3
    } agc_state_t;

    localparam int SETTLE_CNT_W = 16;
    localparam int STEP_SMALL   = 1;

    function automatic int clamp_int(input int v, input int lo, input int hi);
        if (v < lo) begin
            return lo;
        end
        if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage

// File: rtl/agc_gain_ctrl.sv
// rtl/agc_gain_ctrl.sv - AGC loop: compares RMS against a dead-band and steps the PGA gain code
module agc_gain_ctrl
    import agc_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int GAIN_BITS      = 6,
    parameter int GAIN_MIN       = 0,
    parameter int GAIN_MAX       = 63,
    parameter int GAIN_INIT      = 32,
    parameter int STEP_BIG       = 4,
    parameter int SETTLE_SAMPLES = 256
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     rms_TDATA,
    input  logic                 rms_TVALID,
    input  logic                 enable,
    input  logic [WIDTH-1:0]     target_rms,
    input  logic [WIDTH-1:0]     hyst,
    output logic [GAIN_BITS-1:0] gain_TDATA,
    output logic                 gain_TVALID,
    input  logic                 gain_TREADY,
    output logic                 at_min,
    output logic                 at_max,
    output logic                 locked
);

    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE_SAMPLES);
    localparam logic [GAIN_BITS-1:0]    GAIN_RST    = GAIN_BITS'(GAIN_INIT);

    agc_state_t                state_q, state_d;
    logic [GAIN_BITS-1:0]      gain_q, gain_d;
    logic                      valid_q, valid_d;
    logic [SETTLE_CNT_W-1:0]   cnt_q, cnt_d;
    logic                      locked_q, locked_d;

    logic [WIDTH:0]            rms_w, hi_w, lo_w, twice_w;
    int                        cand;
    logic [GAIN_BITS-1:0]      track_gain;
    logic                      track_change;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            gain_q   <= GAIN_RST;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gain_q   <= gain_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
        end
    end

    // Thresholds carry one extra bit so target+hyst and 2*target never wrap.
    always_comb begin
        rms_w   = {1'b0, rms_TDATA};
        hi_w    = {1'b0, target_rms} + {1'b0, hyst};
        lo_w    = (target_rms >= hyst) ? ({1'b0, target_rms} - {1'b0, hyst}) : '0;
        twice_w = {target_rms, 1'b0};

        if (rms_w > twice_w) begin
            cand = int'(gain_q) - STEP_BIG;
        end else if (rms_w > hi_w) begin
            cand = int'(gain_q) - STEP_SMALL;
        end else if (rms_w < lo_w) begin
            cand = int'(gain_q) + STEP_SMALL;
        end else begin
            cand = int'(gain_q);
        end

        track_gain   = GAIN_BITS'(clamp_int(cand, GAIN_MIN, GAIN_MAX));
        track_change = (track_gain != gain_q);
    end

    always_comb begin
        state_d  = state_q;
        gain_d   = gain_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        locked_d = locked_q;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_SYNC;
                    valid_d = 1'b1;
                end
            end
            // An offered code is never withdrawn; enable is only honoured after the handshake.
            ST_SYNC: begin
                if (gain_TREADY) begin
                    valid_d = 1'b0;
                    if (!enable) begin
                        state_d = ST_IDLE;
                    end else if (SETTLE_LOAD == '0) begin
                        state_d = ST_TRACK;
                    end else begin
                        state_d = ST_SETTLE;
                        cnt_d   = SETTLE_LOAD;
                    end
                end
            end
            ST_SETTLE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (rms_TVALID) begin
                    if (cnt_q <= SETTLE_CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = ST_TRACK;
                    end else begin
                        cnt_d = cnt_q - SETTLE_CNT_W'(1);
                    end
                end
            end
            ST_TRACK: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (rms_TVALID) begin
                    if (track_change) begin
                        gain_d  = track_gain;
                        state_d = ST_SYNC;
                        valid_d = 1'b1;
                    end else begin
                        locked_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase

        if (state_d != ST_TRACK) begin
            locked_d = 1'b0;
        end
    end

    always_comb begin
        gain_TDATA  = gain_q;
        gain_TVALID = valid_q;
        at_min      = (gain_q == GAIN_BITS'(GAIN_MIN));
        at_max      = (gain_q == GAIN_BITS'(GAIN_MAX));
        locked      = locked_q;
    end

endmodule

// File: tb/tb_agc_gain_ctrl.sv
// tb/tb_agc_gain_ctrl.sv - self-checking bench for agc_gain_ctrl against a behavioural loop model
module tb_agc_gain_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] rms_TDATA;
    logic        rms_TVALID;
    logic        enable;
    logic [15:0] target_rms;
    logic [15:0] hyst;
    logic [5:0]  gain_TDATA;
    logic        gain_TVALID;
    logic        gain_TREADY;
    logic        at_min;
    logic        at_max;
    logic        locked;

    int n_cmp = 0;
    int n_bad = 0;

    // model: phase 0 idle, 1 offering a code, 2 discarding samples, 3 tracking
    int m_ph     = 0;
    int m_gain   = 32;
    int m_valid  = 0;
    int m_locked = 0;
    int m_cnt    = 0;

    always #5 clk = ~clk;

    agc_gain_ctrl #(
        .WIDTH(16), .GAIN_BITS(6), .GAIN_MIN(0), .GAIN_MAX(63),
        .GAIN_INIT(32), .STEP_BIG(4), .SETTLE_SAMPLES(4)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .rms_TDATA(rms_TDATA), .rms_TVALID(rms_TVALID), .enable(enable),
        .target_rms(target_rms), .hyst(hyst),
        .gain_TDATA(gain_TDATA), .gain_TVALID(gain_TVALID), .gain_TREADY(gain_TREADY),
        .at_min(at_min), .at_max(at_max), .locked(locked)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        int r, t, h, hi, lo, ng;
        if (!reset_n) begin
            m_ph = 0; m_gain = 32; m_valid = 0; m_locked = 0; m_cnt = 0;
        end else begin
            case (m_ph)
                0: if (enable) begin m_ph = 1; m_valid = 1; end
                1: if (gain_TREADY) begin
                    m_valid = 0;
                    if (!enable) m_ph = 0;
                    else begin m_ph = 2; m_cnt = 4; end
                end
                2: if (!enable) m_ph = 0;
                   else if (rms_TVALID) begin
                       m_cnt = m_cnt - 1;
                       if (m_cnt == 0) m_ph = 3;
                   end
                default: if (!enable) begin m_ph = 0; m_locked = 0; end
                   else if (rms_TVALID) begin
                       r = rms_TDATA; t = target_rms; h = hyst;
                       hi = t + h;
                       lo = (t > h) ? t - h : 0;
                       if (r > 2 * t)   ng = m_gain - 4;
                       else if (r > hi) ng = m_gain - 1;
                       else if (r < lo) ng = m_gain + 1;
                       else             ng = m_gain;
                       if (ng < 0)  ng = 0;
                       if (ng > 63) ng = 63;
                       if (ng != m_gain) begin
                           m_gain = ng; m_ph = 1; m_valid = 1; m_locked = 0;
                       end else begin
                           m_locked = 1;
                       end
                   end
            endcase
        end
    end

    always @(negedge clk) begin
        chk("valid",  gain_TVALID, m_valid);
        chk("gain",   gain_TDATA,  m_gain);
        chk("locked", locked,      m_locked);
        chk("at_min", at_min,      m_gain == 0);
        chk("at_max", at_max,      m_gain == 63);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int r);
        rms_TDATA  = 16'(r);
        rms_TVALID = 1'b1;
        cyc();
        rms_TVALID = 1'b0;
    endtask

    task automatic upd(input int r, input string nm, input int exp_gain);
        sample(r);
        chk({nm, "_valid"}, gain_TVALID, 1);
        chk({nm, "_gain"},  gain_TDATA,  exp_gain);
        gain_TREADY = 1'b1;
        cyc();
        repeat (4) sample(int'(target_rms));
    endtask

    initial begin
        int sel, r, t;
        enable = 1'b0; rms_TVALID = 1'b0; rms_TDATA = '0; gain_TREADY = 1'b0;
        target_rms = 16'd1000; hyst = 16'd50;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", gain_TVALID, 0);
        chk("rst_gain",  gain_TDATA,  32);
        chk("rst_lock",  locked,      0);

        reset_n = 1'b1; enable = 1'b1; gain_TREADY = 1'b1;
        cyc();
        chk("en_valid", gain_TVALID, 1);
        chk("en_gain",  gain_TDATA,  32);
        cyc();
        chk("hs_valid", gain_TVALID, 0);
        repeat (4) sample(100);
        chk("settle_valid", gain_TVALID, 0);
        chk("settle_gain",  gain_TDATA,  32);

        upd(1100, "dn1", 31);
        upd(900,  "up1", 32);
        upd(900,  "up2", 33);
        upd(1100, "dn2", 32);
        sample(1020);
        chk("hold_valid", gain_TVALID, 0);
        chk("hold_lock",  locked,      1);
        upd(2500, "big", 28);
        upd(1100, "dn3", 27);
        for (int g = 23; g >= 3; g -= 4) upd(2500, "bigrun", g);
        upd(1100, "dn4", 2);
        upd(2500, "tomin", 0);
        chk("at_min_lit", at_min, 1);
        sample(2500);
        chk("min_hold_valid", gain_TVALID, 0);
        chk("min_hold_lock",  locked,      1);

        for (int g = 1; g <= 63; g++) upd(100, "climb", g);
        sample(100);
        chk("max_hold_valid", gain_TVALID, 0);
        chk("max_flag",       at_max,      1);
        chk("max_lock",       locked,      1);

        sample(1100);
        gain_TREADY = 1'b0; enable = 1'b0;
        repeat (10) begin
            cyc();
            chk("stall_valid", gain_TVALID, 1);
            chk("stall_gain",  gain_TDATA,  62);
        end
        gain_TREADY = 1'b1;
        cyc();
        chk("stall_done", gain_TVALID, 0);
        sample(100);
        chk("idle_ign_valid", gain_TVALID, 0);
        chk("idle_ign_gain",  gain_TDATA,  62);

        enable = 1'b1; gain_TREADY = 1'b0;
        cyc();
        chk("pre_rst_valid", gain_TVALID, 1);
        #3 reset_n = 1'b0;
        #1;
        chk("async_valid", gain_TVALID, 0);
        chk("async_gain",  gain_TDATA,  32);
        enable = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;

        for (int c = 0; c < 4000; c++) begin
            if (c % 400 == 0) begin
                sel = $urandom_range(0, 3);
                case (sel)
                    0: begin target_rms = 16'd1000; hyst = 16'd50; end
                    1: begin target_rms = 16'($urandom_range(0, 100)); hyst = 16'($urandom_range(0, 200)); end
                    2: begin target_rms = 16'($urandom); hyst = 16'($urandom_range(0, 1023)); end
                    default: begin target_rms = 16'($urandom_range(40000, 65535)); hyst = '0; end
                endcase
            end
            t = target_rms;
            case ($urandom_range(0, 3))
                0: r = t + $urandom_range(0, 200) - 100;
                1: r = 2 * t + $urandom_range(0, 4) - 2;
                2: r = t + int'(hyst) + $urandom_range(0, 2) - 1;
                default: r = $urandom_range(0, 65535);
            endcase
            if (r < 0) r = 0;
            if (r > 65535) r = 65535;
            rms_TDATA   = 16'(r);
            rms_TVALID  = 1'($urandom_range(0, 1));
            gain_TREADY = 1'($urandom_range(0, 1));
            enable      = ($urandom_range(0, 99) < 97);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/agc_gain_ctrl.md
AGC_GAIN_CTRL -- requirements
Module: agc_gain_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, RMS input width.
REQ-002 SHALL have parameter GAIN_BITS, default 6, PGA gain code width.
REQ-003 SHALL have parameter GAIN_MIN, default 0, lowest legal gain code.
REQ-004 SHALL have parameter GAIN_MAX, default 63, highest legal gain code.
REQ-005 SHALL have parameter GAIN_INIT, default 32, gain code after reset.
REQ-006 SHALL have parameter STEP_BIG, default 4, coarse step size.
REQ-007 SHALL have parameter SETTLE_SAMPLES, default 256, RMS samples discarded after any gain change (16 bits).
REQ-008 SHALL use one clock and an asynchronous active-low reset: clk  in  1  clock; reset_n  in  1  async active-low reset.
REQ-009 rms_TDATA  in  WIDTH  unsigned RMS estimate from the RMS stage.
REQ-010 rms_TVALID  in  1  RMS sample strobe (no backpressure).
REQ-011 enable  in  1  loop enable.
REQ-012 target_rms  in  WIDTH  unsigned desired RMS.
REQ-013 hyst  in  WIDTH  unsigned dead-band half-width.
REQ-014 gain_TDATA  out  GAIN_BITS  gain code to PGA driver.
REQ-015 gain_TVALID  out  1  gain code valid.
REQ-016 gain_TREADY  in  1  PGA driver accepts code.
REQ-017 at_min / at_max  out  1 each  registered gain == GAIN_MIN / == GAIN_MAX.
REQ-018 locked  out  1  high while in TRACK and last decision was "no change".

Function
REQ-019 SHALL implement FSM states IDLE, SYNC, SETTLE, TRACK.
REQ-020 IDLE: gain held; on enable=1 go to SYNC and drive current gain on gain_TDATA with gain_TVALID=1 the next cycle.
REQ-021 SYNC: gain_TVALID and gain_TDATA held stable until gain_TREADY=1; on handshake go to SETTLE with settle counter = SETTLE_SAMPLES, gain_TVALID=0 next cycle.
REQ-022 SETTLE: counter decrements on each rms_TVALID; at reaching 0 go to TRACK; SETTLE_SAMPLES=0 goes directly to TRACK.
REQ-023 TRACK: on rms_TVALID, hi = target_rms+hyst and lo = target_rms-hyst computed at WIDTH+1 bits, lo saturated at 0.
REQ-024 TRACK decision: rms > 2*target_rms (WIDTH+1 bits) -> gain -= STEP_BIG; else rms > hi -> gain -= 1; rms < lo -> gain += 1; else no change.
REQ-025 New gain SHALL saturate to [GAIN_MIN, GAIN_MAX]; if saturated result equals current gain, treat as no change.
REQ-026 Change: register new gain, enter SYNC; gain_TVALID high exactly 1 cycle after the rms_TVALID cycle.
REQ-027 No change: stay in TRACK, set locked=1; any change clears locked.
REQ-028 rms_TVALID in IDLE or SYNC SHALL be ignored.
REQ-029 enable=0 in SETTLE or TRACK -> IDLE next cycle; in SYNC the handshake SHALL complete first, then IDLE (no TVALID retraction).
REQ-030 gain_TVALID SHALL never drop without a handshake.

Reset
REQ-031 On reset_n=0 (async): state IDLE, gain = GAIN_INIT, gain_TVALID=0, settle counter 0, locked=0; at_min/at_max follow gain.
REQ-032 Reset mid-handshake SHALL drop gain_TVALID immediately; no pending update is retained.

Structure
REQ-033 State enum agc_state_t and STEP/width constants SHALL live in shared package agc_pkg.
REQ-034 Single module, no sub-modules; all arithmetic in one registered decision stage.

Verification (WIDTH=16, GAIN_INIT=32, SETTLE_SAMPLES=4, target=1000, hyst=50)
REQ-035 Reset, enable=1, TREADY=1 -> gain_TVALID pulse with 32, then 4 RMS samples ignored, then TRACK.
REQ-036 TRACK, rms=1100 -> gain 31 issued next cycle; rms=900 -> 33; rms=1020 -> no update, locked=1.
REQ-037 TRACK, rms=2500 -> gain 28; from gain 2 -> gain 0, at_min=1; further high RMS -> no update.
REQ-038 Gain 63, rms=100 -> no update, at_max=1, locked=1.
REQ-039 TREADY held low 10 cycles during SYNC, enable dropped -> TVALID/TDATA stable, after handshake state IDLE.
REQ-040 reset_n pulsed low while gain_TVALID=1 -> TVALID 0 asynchronously, gain 32.
